// File: rtl/serial_add_pkg.sv
// ----------------------------------------------------------------------------
// serial_add_pkg : shared state encoding and default sizes for serial_add_arbiter
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package serial_add_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/full_adder.sv
// ----------------------------------------------------------------------------
// full_adder : single-bit full adder cell
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

`default_nettype wire

// File: rtl/serial_add_arbiter.sv
// ----------------------------------------------------------------------------
// serial_add_arbiter : two requesters share one full_adder via a round-robin
//                      arbiter and an LSB-first bit-serial add
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module serial_add_arbiter
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic [1:0]       grant,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  state_e             state_q, state_d;
  logic [1:0]         grant_q, grant_d;
  logic               winner_q, winner_d;
  logic               last_q, last_d;
  logic [WIDTH-1:0]   op_a_q, op_a_d;
  logic [WIDTH-1:0]   op_b_q, op_b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_out_q, carry_out_d;
  logic               done_id_q, done_id_d;
  logic               win;
  logic               fa_s;
  logic               fa_c;

  full_adder u_fa (
    .a    (op_a_q[0]),
    .b    (op_b_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_c)
  );

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    winner_d    = winner_q;
    last_d      = last_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    res_d       = res_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    carry_out_d = carry_out_q;
    done_id_d   = done_id_q;
    win         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req != 2'b00) begin
          // On a tie, the requester not served last goes first
          win      = (req == 2'b11) ? ~last_q : req[1];
          winner_d = win;
          grant_d  = win ? 2'b10 : 2'b01;
          op_a_d   = win ? a1 : a0;
          op_b_d   = win ? b1 : b0;
          carry_d  = 1'b0;
          cnt_d    = '0;
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        op_a_d  = op_a_q >> 1;
        op_b_d  = op_b_q >> 1;
        res_d   = {fa_s, res_q[WIDTH-1:1]};
        carry_d = fa_c;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          // Publish the result so it is visible during the DONE cycle
          sum_d       = {fa_s, res_q[WIDTH-1:1]};
          carry_out_d = fa_c;
          done_id_d   = winner_q;
          grant_d     = 2'b00;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        last_d  = winner_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      grant_q     <= 2'b00;
      winner_q    <= 1'b0;
      last_q      <= 1'b1;
      op_a_q      <= '0;
      op_b_q      <= '0;
      res_q       <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      sum_q       <= '0;
      carry_out_q <= 1'b0;
      done_id_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      winner_q    <= winner_d;
      last_q      <= last_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      res_q       <= res_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      carry_out_q <= carry_out_d;
      done_id_q   <= done_id_d;
    end
  end

  assign grant     = grant_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign done_id   = done_id_q;
  assign sum       = sum_q;
  assign carry_out = carry_out_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_add_arbiter.sv
// ----------------------------------------------------------------------------
// tb_serial_add_arbiter : directed self-checking bench for serial_add_arbiter
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_serial_add_arbiter;

  localparam int WIDTH = 8;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req;
  logic [WIDTH-1:0] a0, b0, a1, b1;
  logic [1:0]       grant;
  logic             busy;
  logic             done;
  logic             done_id;
  logic [WIDTH-1:0] sum;
  logic             carry_out;

  int vectors = 0;
  int errs    = 0;

  serial_add_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .a0        (a0),
    .b0        (b0),
    .a1        (a1),
    .b1        (b1),
    .grant     (grant),
    .busy      (busy),
    .done      (done),
    .done_id   (done_id),
    .sum       (sum),
    .carry_out (carry_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called in an IDLE cycle with req already driven; returns in the IDLE
  // cycle after DONE with the winner's req bit dropped.
  task automatic do_op(input string tag, input logic [1:0] eg, input logic eid,
                       input logic [7:0] es, input logic ec, input int poke);
    step();
    chk({tag, ".grant"}, 32'(grant), 32'(eg));
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    for (int i = 0; i < WIDTH - 1; i++) begin
      if (i == poke) begin
        a0 = 8'hFF; b0 = 8'hFF; a1 = 8'hFF; b1 = 8'hFF;
      end
      step();
      chk({tag, ".early_done"}, 32'(done), 32'd0);
    end
    step();
    chk({tag, ".done"}, 32'(done), 32'd1);
    chk({tag, ".done_id"}, 32'(done_id), 32'(eid));
    chk({tag, ".sum"}, 32'(sum), 32'(es));
    chk({tag, ".carry_out"}, 32'(carry_out), 32'(ec));
    chk({tag, ".grant_done"}, 32'(grant), 32'd0);
    chk({tag, ".busy_done"}, 32'(busy), 32'd1);
    req[eid] = 1'b0;
    step();
    chk({tag, ".done_pulse"}, 32'(done), 32'd0);
    chk({tag, ".busy_idle"}, 32'(busy), 32'd0);
    chk({tag, ".sum_held"}, 32'(sum), 32'(es));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = 2'b00;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    do_reset();
    chk("rst.grant", 32'(grant), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.done_id", 32'(done_id), 32'd0);
    chk("rst.sum", 32'(sum), 32'd0);
    chk("rst.carry_out", 32'(carry_out), 32'd0);

    // Idle with no request stays idle
    step();
    chk("idle.grant", 32'(grant), 32'd0);

    // Lone requester 0
    a0 = 8'h0F; b0 = 8'h01; req = 2'b01;
    do_op("t1", 2'b01, 1'b0, 8'h10, 1'b0, -1);

    // Lone requester 1, overflow, then back-to-back
    a1 = 8'hFF; b1 = 8'h01; req = 2'b10;
    do_op("t2a", 2'b10, 1'b1, 8'h00, 1'b1, -1);
    a1 = 8'hAA; b1 = 8'h55; req = 2'b10;
    do_op("t2b", 2'b10, 1'b1, 8'hFF, 1'b0, -1);

    // Tie from reset: requester 0 first, then alternation
    do_reset();
    a0 = 8'h3C; b0 = 8'h0F; a1 = 8'h80; b1 = 8'h80; req = 2'b11;
    do_op("t3a", 2'b01, 1'b0, 8'h4B, 1'b0, -1);
    do_op("t3b", 2'b10, 1'b1, 8'h00, 1'b1, -1);
    req = 2'b11;
    a0 = 8'h01; b0 = 8'h02; a1 = 8'h10; b1 = 8'h20;
    do_op("t3c", 2'b01, 1'b0, 8'h03, 1'b0, -1);
    req[0] = 1'b1;
    do_op("t3d", 2'b10, 1'b1, 8'h30, 1'b0, -1);
    req[1] = 1'b1;
    do_op("t3e", 2'b01, 1'b0, 8'h03, 1'b0, -1);
    req = 2'b00;

    // Operands captured at grant; later changes ignored
    a0 = 8'h03; b0 = 8'h04; req = 2'b01;
    do_op("t4", 2'b01, 1'b0, 8'h07, 1'b0, 2);

    // Reset mid-shift at bit index 4
    a0 = 8'h12; b0 = 8'h34; req = 2'b01;
    step();
    chk("t5.grant", 32'(grant), 32'd1);
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5.grant_rst", 32'(grant), 32'd0);
    chk("t5.busy_rst", 32'(busy), 32'd0);
    chk("t5.done_rst", 32'(done), 32'd0);
    chk("t5.sum_rst", 32'(sum), 32'd0);
    chk("t5.carry_rst", 32'(carry_out), 32'd0);
    do_op("t5b", 2'b01, 1'b0, 8'h46, 1'b0, -1);

    // Reset and request on the same edge: reset wins
    a0 = 8'hC0; b0 = 8'h50; req = 2'b01; rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6.grant", 32'(grant), 32'd0);
    chk("t6.busy", 32'(busy), 32'd0);
    do_op("t6b", 2'b01, 1'b0, 8'h10, 1'b1, -1);

    // Pointer back at reset value: tie goes to requester 0
    do_reset();
    a0 = 8'h05; b0 = 8'h06; a1 = 8'h07; b1 = 8'h08; req = 2'b11;
    do_op("t7a", 2'b01, 1'b0, 8'h0B, 1'b0, -1);
    do_op("t7b", 2'b10, 1'b1, 8'h0F, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_add_arbiter.md
Name: serial_add_arbiter

Overview:
Shares one full_adder cell between two requesters by running a bit-serial add of two WIDTH-bit operands, LSB first, one bit per clock. It has a round-robin arbiter, a req/grant/done handshake and a sequencing FSM. It sits beside the LED counter datapath as the low-area alternative to a parallel ripple-carry chain.

Parameters:
WIDTH, 8, operand/sum width in bits (>= 2)
CNT_W, 3, bit-index counter width; must satisfy 2**CNT_W >= WIDTH

Ports:
clk  in  1  single system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
req  in  2  request per requester; req[i] held high until done with done_id==i
a0  in  WIDTH  operand A, requester 0
b0  in  WIDTH  operand B, requester 0
a1  in  WIDTH  operand A, requester 1
b1  in  WIDTH  operand B, requester 1
grant  out  2  one-hot owner of the adder, 0 when free
busy  out  1  high in SHIFT and DONE
done  out  1  one-cycle pulse, result valid
done_id  out  1  requester that owns current sum
sum  out  WIDTH  result, held until next done
carry_out  out  1  final carry, held with sum

Behaviour:
- Reset (sync, rst high at an edge): state=IDLE, grant=0, busy=0, done=0, done_id=0, sum=0, carry_out=0, carry flop=0, bit index=0, rr pointer set so requester 0 wins the first tie.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: if req!=0 at edge T, go to SHIFT.
  - Winner: the only requester asking, or on a tie the one not served last.
  - grant=onehot(winner); latch winner's a/b into operand shift registers; carry flop=0; index=0.
  - If req==0, stay in IDLE.
- SHIFT: each edge feeds opA[0], opB[0] and the carry flop to full_adder.
  - Sum bit enters the result shift register at the MSB, which shifts right.
  - The carry flop takes the carry out; the operand registers shift right; index increments.
  - After the edge that processes bit WIDTH-1 (edge T+WIDTH), go to DONE.
- DONE, one cycle:
  - done=1; done_id=winner; sum and carry_out update from the result registers, visible in this cycle; grant=0.
  - rr pointer records the winner; go to IDLE at the next edge.
- Latency: req sampled at edge T; done high in the cycle after edge T+WIDTH; the earliest next grant is at edge T+WIDTH+2.
- Handshake:
  - The requester drops req in the cycle it sees done with its id.
  - req still high at the DONE->IDLE edge has no effect, because the FSM samples req only in IDLE.
  - req still high in the following IDLE cycle counts as a new request.
- The rr pointer affects ties only: a lone requester is always granted, including back-to-back.
- Operands are captured at grant; changes on a*/b* during SHIFT/DONE are ignored.
- Arithmetic is modulo 2**WIDTH with no carry-in; carry_out = bit WIDTH of the true sum.
- Deassertion of req during SHIFT is ignored; the operation completes and done still pulses.
- Reset mid-operation: abort immediately, return all outputs to reset values, no done pulse, pointer to reset value.
- sum/carry_out/done_id change only in DONE or on reset.

Decomposition:
- Package serial_add_pkg: state encoding constants (IDLE, SHIFT, DONE), default WIDTH/CNT_W.
- Sub-module: one instance of the existing full_adder cell for the bit slice.
- Arbiter, FSM and shift registers stay in serial_add_arbiter.

Test Plan:
1. After reset, req=01, a0=0x0F, b0=0x01 -> grant=01 from the cycle after the sampling edge; done pulse 9 cycles later with done_id=0, sum=0x10, carry_out=0; busy low after DONE.
2. req=10, a1=0xFF, b1=0x01 -> done_id=1, sum=0x00, carry_out=1; also a1=0xAA, b1=0x55 -> sum=0xFF, carry_out=0.
3. req=11 held from reset, each requester dropping req on its own done -> first grant=01 (sum of a0+b0), next grant=10 exactly 2 cycles after that done; with both re-raised, grants alternate 01,10,01.
4. Grant to 0 with a0=0x03, b0=0x04, then drive a0=0xFF at bit 3 -> sum=0x07, carry_out=0 (capture at grant).
5. rst high for one cycle during SHIFT at bit index 4 -> next cycle grant=0, busy=0, sum=0, carry_out=0, no done pulse; with req=01 still high, a fresh full-length operation follows.
6. Assert rst and req=01 on the same edge -> reset wins (state stays IDLE, grant=0); with req=01 held, grant=01 follows one edge later.
